// File: rtl/alu_pkg.sv
// Types shared by the ALU, its operand sequencer and their benches.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_MUL  = 4'd3,
        OP_DIV  = 4'd4,
        OP_MOD  = 4'd5,
        OP_AND  = 4'd6,
        OP_OR   = 4'd7,
        OP_XOR  = 4'd8
    } op_t;

    typedef enum logic [2:0] {
        ST_A    = 3'd0,
        ST_B    = 3'd1,
        ST_OP   = 3'd2,
        ST_EXEC = 3'd3,
        ST_SHOW = 3'd4
    } seq_state_t;

    function automatic logic op_is_valid(op_t op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter, rising-edge pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          level;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            pulse <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                // level has differed for DEBOUNCE_CYCLES samples in a row
                level <= ~level;
                cnt   <= '0;
                pulse <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Operand/opcode entry stage for the board ALU: debounced buttons step A -> B -> OP -> EXEC -> SHOW.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic [3:0]       op_sw,
    input  logic             cin_sw,
    input  logic             btn_enter,
    input  logic             btn_cancel,
    input  logic [WIDTH-1:0] alu_S,
    input  logic             alu_Cout,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             Cin,
    output logic             boton0,
    output logic             boton1,
    output logic             boton2,
    output logic             boton3,
    output logic [WIDTH-1:0] result,
    output logic             result_cout,
    output logic             result_valid,
    output logic             op_error,
    output logic [2:0]       state_dbg
);

    localparam int NUM_BTN = 2;

    logic [NUM_BTN-1:0] btn_raw, btn_pulse;
    logic               enter_p, cancel_p;

    assign btn_raw  = {btn_cancel, btn_enter};
    assign enter_p  = btn_pulse[0];
    assign cancel_p = btn_pulse[1];

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .rst   (rst),
            .raw   (btn_raw[i]),
            .pulse (btn_pulse[i])
        );
    end

    logic [1:0][WIDTH-1:0] sw_sync;
    logic [1:0][3:0]       op_sync;
    logic [1:0]            cin_sync;
    logic [WIDTH-1:0]      sw_s;
    logic [3:0]            op_s;
    logic                  cin_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_sync  <= '0;
            op_sync  <= '0;
            cin_sync <= '0;
        end else begin
            sw_sync  <= {sw_sync[0], sw};
            op_sync  <= {op_sync[0], op_sw};
            cin_sync <= {cin_sync[0], cin_sw};
        end
    end

    assign sw_s  = sw_sync[1];
    assign op_s  = op_sync[1];
    assign cin_s = cin_sync[1];

    seq_state_t state, state_nx;
    logic       op_ok;
    logic [3:0] op_q;

    assign op_ok = op_is_valid(op_t'(op_s));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_A;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (cancel_p) begin
            state_nx = ST_A;
        end else begin
            case (state)
                ST_A:    if (enter_p) state_nx = ST_B;
                ST_B:    if (enter_p) state_nx = ST_OP;
                ST_OP:   if (enter_p && op_ok) state_nx = ST_EXEC;
                ST_EXEC: state_nx = ST_SHOW;
                ST_SHOW: if (enter_p) state_nx = ST_A;
                default: state_nx = ST_A;
            endcase
        end
    end

    // op_q doubles as the ALU opcode lines: nonzero only from EXEC through SHOW
    always_ff @(posedge clk) begin
        if (rst) begin
            A           <= '0;
            B           <= '0;
            Cin         <= 1'b0;
            op_q        <= '0;
            result      <= '0;
            result_cout <= 1'b0;
            op_error    <= 1'b0;
        end else if (cancel_p) begin
            op_q     <= '0;
            op_error <= 1'b0;
        end else begin
            case (state)
                ST_A: if (enter_p) A <= sw_s;
                ST_B: if (enter_p) B <= sw_s;
                ST_OP: begin
                    if (enter_p && op_ok) begin
                        op_q     <= op_s;
                        Cin      <= cin_s;
                        op_error <= 1'b0;
                    end else if (enter_p) begin
                        op_error <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    result      <= alu_S;
                    result_cout <= alu_Cout;
                end
                ST_SHOW: if (enter_p) op_q <= '0;
                default: ;
            endcase
        end
    end

    assign {boton3, boton2, boton1, boton0} = op_q;
    assign result_valid = (state == ST_SHOW);
    assign state_dbg    = state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small behavioural ALU closing the loop.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw, op_sw;
    logic       cin_sw, btn_enter, btn_cancel;
    logic [3:0] alu_S;
    logic       alu_Cout;
    logic [3:0] A, B, result;
    logic       Cin, boton0, boton1, boton2, boton3;
    logic       result_cout, result_valid, op_error;
    logic [2:0] state_dbg;

    alu_op_sequencer #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .sw(sw), .op_sw(op_sw), .cin_sw(cin_sw),
        .btn_enter(btn_enter), .btn_cancel(btn_cancel),
        .alu_S(alu_S), .alu_Cout(alu_Cout),
        .A(A), .B(B), .Cin(Cin),
        .boton0(boton0), .boton1(boton1), .boton2(boton2), .boton3(boton3),
        .result(result), .result_cout(result_cout), .result_valid(result_valid),
        .op_error(op_error), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Board ALU behaviour: SUB computes B - A - Cin with borrow on Cout
    logic [4:0] alu_t;
    logic [3:0] op_lines;
    always_comb begin
        op_lines = {boton3, boton2, boton1, boton0};
        alu_t = '0;
        case (op_lines)
            4'd1: alu_t = {1'b0, A} + {1'b0, B} + {4'b0, Cin};
            4'd2: alu_t = {1'b0, B} - {1'b0, A} - {4'b0, Cin};
            4'd6: alu_t = {1'b0, A & B};
            4'd7: alu_t = {1'b0, A | B};
            4'd8: alu_t = {1'b0, A ^ B};
            default: alu_t = '0;
        endcase
        alu_S    = alu_t[3:0];
        alu_Cout = alu_t[4];
    end

    int n_chk = 0;
    int n_pass = 0;
    int exec_cnt = 0;

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (state_dbg == 3'd3) exec_cnt++;
        end
    endtask

    task automatic press(input logic en, input logic cn);
        btn_enter  = en;
        btn_cancel = cn;
        cyc(8);
        btn_enter  = 1'b0;
        btn_cancel = 1'b0;
        cyc(8);
    endtask

    typedef struct {
        logic [3:0] a, b, op;
        logic       cin;
        logic [3:0] res;
        logic       cout;
    } vec_t;

    vec_t vt[6];

    initial begin
        int   changes;
        logic [2:0] prev;

        vt[0] = '{4'b0011, 4'b0110, 4'b0001, 1'b0, 4'b1001, 1'b0};
        vt[1] = '{4'b1111, 4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b1};
        vt[2] = '{4'b1000, 4'b0101, 4'b0010, 1'b0, 4'b1101, 1'b1};
        vt[3] = '{4'b0111, 4'b1000, 4'b0001, 1'b1, 4'b0000, 1'b1};
        vt[4] = '{4'b1100, 4'b1010, 4'b0110, 1'b0, 4'b1000, 1'b0};
        vt[5] = '{4'b1100, 4'b1010, 4'b1000, 1'b0, 4'b0110, 1'b0};

        rst = 1'b1; sw = '0; op_sw = '0; cin_sw = 1'b0;
        btn_enter = 1'b0; btn_cancel = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        chk("rst_state", state_dbg, 3'd0);
        chk("rst_A", A, 4'd0);
        chk("rst_B", B, 4'd0);
        chk("rst_boton", op_lines, 4'd0);
        chk("rst_valid", result_valid, 1'b0);
        chk("rst_result", {result_cout, result}, 5'd0);
        chk("rst_err", op_error, 1'b0);

        for (int i = 0; i < 6; i++) begin
            sw = vt[i].a; press(1'b1, 1'b0);
            sw = vt[i].b; press(1'b1, 1'b0);
            op_sw = vt[i].op; cin_sw = vt[i].cin;
            exec_cnt = 0;
            press(1'b1, 1'b0);
            chk($sformatf("v%0d_A", i), A, vt[i].a);
            chk($sformatf("v%0d_B", i), B, vt[i].b);
            chk($sformatf("v%0d_res", i), result, vt[i].res);
            chk($sformatf("v%0d_cout", i), result_cout, vt[i].cout);
            chk($sformatf("v%0d_valid", i), result_valid, 1'b1);
            chk($sformatf("v%0d_state", i), state_dbg, 3'd4);
            chk($sformatf("v%0d_boton", i), op_lines, vt[i].op);
            chk($sformatf("v%0d_exec1", i), exec_cnt[7:0], 8'd1);
            press(1'b1, 1'b0);
            chk($sformatf("v%0d_back_st", i), state_dbg, 3'd0);
            chk($sformatf("v%0d_back_vld", i), result_valid, 1'b0);
            chk($sformatf("v%0d_back_bot", i), op_lines, 4'd0);
        end

        // reset in the middle of ST_OP
        sw = 4'b0101; press(1'b1, 1'b0);
        sw = 4'b0011; press(1'b1, 1'b0);
        chk("mid_op_state", state_dbg, 3'd2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("midrst_state", state_dbg, 3'd0);
        chk("midrst_A", A, 4'd0);
        chk("midrst_B", B, 4'd0);
        chk("midrst_boton", op_lines, 4'd0);
        chk("midrst_valid", result_valid, 1'b0);
        cyc(2);

        // bouncing enter: one press, one advance
        sw = 4'b1010;
        changes = 0;
        prev = state_dbg;
        for (int i = 0; i < 26; i++) begin
            if (i < 10)      btn_enter = ~btn_enter;
            else if (i < 18) btn_enter = 1'b1;
            else             btn_enter = 1'b0;
            cyc(1);
            if (state_dbg != prev) changes++;
            prev = state_dbg;
        end
        chk("bounce_changes", changes[7:0], 8'd1);
        chk("bounce_state", state_dbg, 3'd1);
        chk("bounce_A", A, 4'b1010);

        // invalid opcode then a valid one
        sw = 4'b0110; press(1'b1, 1'b0);
        op_sw = 4'b1011; press(1'b1, 1'b0);
        chk("inv_err", op_error, 1'b1);
        chk("inv_state", state_dbg, 3'd2);
        chk("inv_boton", op_lines, 4'd0);
        op_sw = 4'b1000; cin_sw = 1'b0;
        exec_cnt = 0;
        press(1'b1, 1'b0);
        chk("valid_err_clr", op_error, 1'b0);
        chk("valid_exec_seen", exec_cnt[7:0], 8'd1);
        chk("valid_state", state_dbg, 3'd4);
        chk("valid_res", result, 4'b1100);

        // enter + cancel together in ST_SHOW: cancel wins
        sw = 4'b1111;
        press(1'b1, 1'b1);
        chk("both_state", state_dbg, 3'd0);
        chk("both_valid", result_valid, 1'b0);
        chk("both_res", result, 4'b1100);
        chk("both_A", A, 4'b1010);
        chk("both_boton", op_lines, 4'd0);

        // cancel from ST_OP with op_error set, operands retained
        sw = 4'b0001; press(1'b1, 1'b0);
        sw = 4'b0010; press(1'b1, 1'b0);
        op_sw = 4'b0000; press(1'b1, 1'b0);
        chk("zero_op_err", op_error, 1'b1);
        press(1'b0, 1'b1);
        chk("cancel_state", state_dbg, 3'd0);
        chk("cancel_err", op_error, 1'b0);
        chk("cancel_A", A, 4'b0001);
        chk("cancel_B", B, 4'b0010);
        chk("cancel_res", result, 4'b1100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
